// File: rtl/wallace_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : wallace_pipe_ctrl_if
// Brief    : Bundle for the Wallace multiplier pipeline controller. It carries
//            two requester ports, the multiplier launch/return path, the
//            response port and the status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface wallace_pipe_ctrl_if #(
    parameter int LATENCY = 7,
    parameter int TAG_W   = 4
) ();
    localparam int c_INFL_W = $clog2(LATENCY + 1);

    // requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic [31:0]       req0_a;
    logic [31:0]       req0_b;
    logic [TAG_W-1:0]  req0_tag;
    // requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic [31:0]       req1_a;
    logic [31:0]       req1_b;
    logic [TAG_W-1:0]  req1_tag;
    // multiplier datapath
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [63:0]       mul_res;
    // response port
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_data;
    logic              resp_id;
    logic [TAG_W-1:0]  resp_tag;
    // status
    logic [c_INFL_W-1:0] inflight;
    logic              busy;

    // controller side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_tag,
        input  mul_res, resp_ready,
        output req0_ready, req1_ready, mul_a, mul_b,
        output resp_valid, resp_data, resp_id, resp_tag,
        output inflight, busy
    );

    // environment side (requesters, multiplier, consumer)
    modport master (
        output req0_valid, req0_a, req0_b, req0_tag,
        output req1_valid, req1_a, req1_b, req1_tag,
        output mul_res, resp_ready,
        input  req0_ready, req1_ready, mul_a, mul_b,
        input  resp_valid, resp_data, resp_id, resp_tag,
        input  inflight, busy
    );
endinterface
`default_nettype wire

// File: rtl/wallace_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wallace_pipe_ctrl
// Brief    : Credit-based launch controller for a non-stalling Wallace tree
//            multiplier pipeline. Round-robin arbitration between two
//            requesters, a {valid,id,tag} side pipe aligned with the product,
//            and a response FIFO that can never overflow because space is
//            reserved before launch.
// Revision : 1.0 - initial release
// ============================================================================
module wallace_pipe_ctrl #(
    parameter int LATENCY = 7,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    wallace_pipe_ctrl_if.slave   bus
);
    localparam int c_INFL_W = $clog2(LATENCY + 1);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);

    // side pipe carrying operation identity alongside the datapath
    logic [LATENCY-1:0] r_sr_vld;
    logic [LATENCY-1:0] r_sr_id;
    logic [TAG_W-1:0]   r_sr_tag [LATENCY];

    // response FIFO
    logic [63:0]        r_fifo_data [DEPTH];
    logic               r_fifo_id   [DEPTH];
    logic [TAG_W-1:0]   r_fifo_tag  [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_INFL_W-1:0] r_inflight;
    logic                r_prio;      // 1: requester 1 wins a tie

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_occ;
    logic        w_permit;
    logic        w_sel1;
    logic        w_xfer;
    logic [TAG_W-1:0] w_gnt_tag;

    assign w_push = r_sr_vld[LATENCY-1];
    assign w_pop  = (r_count != '0) && bus.resp_ready;

    // Credits: everything launched but not yet popped, with this cycle's
    // push and pop folded in, must stay below the buffer depth.
    assign w_occ    = 32'(r_inflight) + 32'(r_count) + 32'(w_push) - 32'(w_pop);
    assign w_permit = w_occ < 32'(DEPTH);

    // requester 1 is chosen when it is the only one asking or holds priority
    assign w_sel1 = bus.req1_valid && (!bus.req0_valid || r_prio);
    assign w_xfer = w_permit && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = w_permit && bus.req0_valid && !w_sel1;
    assign bus.req1_ready = w_permit && w_sel1;

    assign bus.mul_a = !w_xfer ? 32'd0 : (w_sel1 ? bus.req1_a : bus.req0_a);
    assign bus.mul_b = !w_xfer ? 32'd0 : (w_sel1 ? bus.req1_b : bus.req0_b);
    assign w_gnt_tag = w_sel1 ? bus.req1_tag : bus.req0_tag;

    assign bus.resp_valid = (r_count != '0);
    assign bus.resp_data  = r_fifo_data[r_rd_ptr];
    assign bus.resp_id    = r_fifo_id[r_rd_ptr];
    assign bus.resp_tag   = r_fifo_tag[r_rd_ptr];
    assign bus.inflight   = r_inflight;
    assign bus.busy       = (r_inflight != '0) || (r_count != '0);

    // Valid bits of the side pipe; only these need clearing on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sr_vld <= '0;
        end else begin
            r_sr_vld[0] <= w_xfer;
            for (int i = 1; i < LATENCY; i++) begin
                r_sr_vld[i] <= r_sr_vld[i-1];
            end
        end
    end

    // Identity payload of the side pipe, qualified by the valid bits.
    always_ff @(posedge clk) begin
        r_sr_id[0]  <= w_sel1;
        r_sr_tag[0] <= w_gnt_tag;
        for (int i = 1; i < LATENCY; i++) begin
            r_sr_id[i]  <= r_sr_id[i-1];
            r_sr_tag[i] <= r_sr_tag[i-1];
        end
    end

    // Capture the aligned product and identity into the FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.mul_res;
            r_fifo_id[r_wr_ptr]   <= r_sr_id[LATENCY-1];
            r_fifo_tag[r_wr_ptr]  <= r_sr_tag[LATENCY-1];
        end
    end

    // FIFO pointers and occupancy; pointers wrap explicitly for any DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // In-flight counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inflight <= '0;
            r_prio     <= 1'b0;
        end else begin
            if (w_xfer && !w_push) begin
                r_inflight <= r_inflight + c_INFL_W'(1);
            end else if (!w_xfer && w_push) begin
                r_inflight <= r_inflight - c_INFL_W'(1);
            end
            if (w_xfer) begin
                r_prio <= !w_sel1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wallace_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wallace_pipe_ctrl
// Brief    : Scoreboard bench for wallace_pipe_ctrl with a behavioural
//            multiplier pipeline and a launch-time based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wallace_pipe_ctrl;
    localparam int L  = 7;
    localparam int TW = 4;
    localparam int D  = 8;

    typedef struct {
        logic [63:0]   prod;
        logic          id;
        logic [TW-1:0] tag;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wallace_pipe_ctrl_if #(.LATENCY(L), .TAG_W(TW)) bus ();

    wallace_pipe_ctrl #(.LATENCY(L), .TAG_W(TW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // behavioural multiplier: L register levels, cleared by the same reset
    logic [63:0] mpipe [L];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) mpipe[i] <= 64'd0;
        end else begin
            mpipe[0] <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign bus.mul_res = mpipe[L-1];

    int    total = 0;
    int    bad   = 0;
    resp_t sb[$];      // expected responses in launch order
    int    lq[$];      // launch cycle of every op not yet popped
    int    now   = 0;
    logic  prio  = 1'b0;
    logic  last_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, now);
        end
    endtask

    // One clock of stimulus plus model prediction of the cycle's outputs.
    task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [TW-1:0] t0, input logic v1, input logic [31:0] a1,
                        input logic [31:0] b1, input logic [TW-1:0] t1, input logic rr);
        int    push_n = 0;
        int    buf_n  = 0;
        int    infl_n = 0;
        logic  rv, pop, permit, e0, e1;
        resp_t r;
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_tag = t0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_tag = t1;
        bus.resp_ready = rr;
        #2;
        foreach (lq[i]) begin
            if (lq[i] + L == now)  push_n++;
            if (now >= lq[i] + L + 1) buf_n++;
            else infl_n++;
        end
        rv     = (buf_n > 0);
        pop    = rv && rr;
        permit = (lq.size() + push_n - (pop ? 1 : 0)) < D;
        e1     = permit && v1 && (!v0 || prio);
        e0     = permit && v0 && !e1;
        chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(e1));
        chk("resp_valid", 64'(bus.resp_valid), 64'(rv));
        chk("inflight",   64'(bus.inflight),   64'(infl_n));
        chk("busy",       64'(bus.busy),       64'(infl_n != 0 || rv));
        chk("mul_a", 64'(bus.mul_a), 64'(e0 ? a0 : (e1 ? a1 : 32'd0)));
        chk("mul_b", 64'(bus.mul_b), 64'(e0 ? b0 : (e1 ? b1 : 32'd0)));
        if (pop) void'(lq.pop_front());
        last_gnt = e0 || e1;
        if (last_gnt) begin
            lq.push_back(now);
            r.prod = e1 ? 64'(a1) * 64'(b1) : 64'(a0) * 64'(b0);
            r.id   = e1;
            r.tag  = e1 ? t1 : t0;
            sb.push_back(r);
            prio = !e1;
        end
        now++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    task automatic drain();
        int k = 0;
        while (lq.size() != 0 && k < 100) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
            k++;
        end
        chk("drain_outstanding", 64'(lq.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.resp_ready = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.req0_valid = (i == n - 1);
            #2;
            chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
            chk("rst_inflight",   64'(bus.inflight),   64'd0);
            chk("rst_busy",       64'(bus.busy),       64'd0);
            chk("rst_ready0",     64'(bus.req0_ready), 64'(i == n - 1));
            chk("rst_ready1",     64'(bus.req1_ready), 64'd0);
        end
        lq.delete();
        sb.delete();
        prio = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.req0_valid = 0;
    endtask

    // monitor: pop the scoreboard on every accepted response
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            #3;
            if (rst && bus.resp_valid && bus.resp_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got %h with nothing outstanding", bus.resp_data);
                end else begin
                    r = sb.pop_front();
                    chk("resp_data", bus.resp_data,     r.prod);
                    chk("resp_id",   64'(bus.resp_id),  64'(r.id));
                    chk("resp_tag",  64'(bus.resp_tag), 64'(r.tag));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_tag = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_tag = 0;
        bus.resp_ready = 0;
        do_reset(3);

        // single op, 3*5 tag 2
        step(1, 32'd3, 32'd5, 4'd2, 0, 0, 0, 0, 1'b1);
        idle(L + 4, 1'b1);

        // contention, both valid, consumer always ready
        step(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1, $urandom, $urandom, TW'($urandom_range(0, 15)),
                 1, $urandom, $urandom, TW'($urandom_range(0, 15)), 1'b1);
        drain();

        // backpressure: exactly D launches while the consumer stalls
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, $urandom, $urandom, TW'(i), 0, 0, 0, 0, 1'b0);
            if (last_gnt) acc++;
        end
        chk("bp_accepted", 64'(acc), 64'(D));
        for (int i = 0; i < 40; i++)
            step(1, $urandom, $urandom, TW'(i), 0, 0, 0, 0, 1'b1);
        drain();

        // push and pop together while D-1 entries are buffered
        for (int k = 0; k < 30; k++)
            step((k < 7) || (k == 13), $urandom, $urandom, TW'(k), 0, 0, 0, 0, k >= 20);
        drain();

        // reset with 3 in flight and 2 buffered
        for (int k = 0; k < 9; k++)
            step(k < 5, $urandom, $urandom, TW'(k), 0, 0, 0, 0, 1'b0);
        chk("pre_rst_outstanding", 64'(lq.size()), 64'd5);
        do_reset(2);
        idle(2 * L, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom, TW'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 6, $urandom, $urandom, TW'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 6);
        drain();
        idle(2, 1'b1);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wallace_pipe_ctrl.md
WALLACE_PIPE_CTRL -- requirements
Module: wallace_pipe_ctrl

Interface
REQ-001 Parameter LATENCY, default 7, number of pipeline register levels between operand launch and product output.
REQ-002 Parameter TAG_W, default 4, width of the requester-supplied tag.
REQ-003 Parameter DEPTH, default 8, number of response buffer entries; DEPTH SHALL be >= 2.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset; the same rst SHALL drive the multiplier pipeline registers.
REQ-006 req0_valid / req1_valid  in  1  requester 0/1 has an operation pending.
REQ-007 req0_ready / req1_ready  out  1  grant; an operation transfers when valid&&ready.
REQ-008 req0_a, req0_b, req1_a, req1_b  in  32  unsigned operands.
REQ-009 req0_tag, req1_tag  in  TAG_W  opaque tag returned with the result.
REQ-010 mul_a, mul_b  out  32  operands launched into the multiplier datapath.
REQ-011 mul_res  in  64  product from the last pipeline level.
REQ-012 resp_valid  out  1  response buffer non-empty.
REQ-013 resp_ready  in  1  consumer accepts the head response.
REQ-014 resp_data  out  64  product; resp_id  out  1  originating requester; resp_tag  out  TAG_W  originating tag.
REQ-015 inflight  out  $clog2(LATENCY+1)  operations currently inside the pipeline.
REQ-016 busy  out  1  high when inflight != 0 or resp_valid.

Function
REQ-017 The pipeline has no stall; the controller SHALL guarantee buffer space before launch using credits.
REQ-018 Launch permitted in a cycle only when inflight + count + (push this cycle ? 1 : 0) - (pop this cycle ? 1 : 0) < DEPTH, where count = buffered entries.
REQ-019 At most one launch per cycle; when launch is not permitted both ready outputs SHALL be 0.
REQ-020 Arbitration round-robin: with both valid, grant the requester not granted most recently; pointer updates only on an actual transfer; after reset requester 0 has priority.
REQ-021 ready SHALL depend on valids, credit state, and priority pointer only, never on operand values; single requester valid and credit available -> that requester granted the same cycle.
REQ-022 On transfer, mul_a/mul_b SHALL present the granted operands combinationally in that cycle; with no transfer they SHALL be 0.
REQ-023 A LATENCY-deep shift register SHALL carry {valid, id, tag} alongside the datapath; its output stage aligns with mul_res for the launched operation exactly LATENCY cycles after the transfer edge.
REQ-024 When the aligned valid is 1, {mul_res, id, tag} SHALL be pushed into the response FIFO that cycle.
REQ-025 FIFO: DEPTH entries, circular read/write pointers wrapping at DEPTH-1 -> 0, head presented on resp_*; pop when resp_valid&&resp_ready.
REQ-026 Simultaneous push and pop SHALL both occur, count unchanged; push into empty FIFO visible on resp_valid next cycle (no bypass).
REQ-027 Overflow is impossible by REQ-018; pop of empty FIFO SHALL be ignored.
REQ-028 inflight increments on transfer, decrements on aligned valid, unchanged when both occur in one cycle.
REQ-029 Responses SHALL leave in launch order regardless of requester.

Reset
REQ-030 rst low at a rising edge: shift register valids, FIFO pointers, count, inflight, priority pointer cleared; resp_valid=0, busy=0; both ready reflect REQ-019/020 from cleared state.
REQ-031 Reset mid-operation discards all in-flight and buffered operations; no response for them SHALL appear after reset release.

Verification
REQ-032 Single op: req0 a=3, b=5, tag=2 -> resp_valid rises LATENCY+1 cycles after transfer, resp_data=15, resp_id=0, resp_tag=2.
REQ-033 Contention: both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1...; responses in same order with correct products (e.g. 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001).
REQ-034 Backpressure: resp_ready=0, req0 always valid -> exactly DEPTH transfers accepted, then ready=0; raise resp_ready -> one new grant per pop, no lost or duplicated response.
REQ-035 Simultaneous push/pop with FIFO at DEPTH-1 entries -> count stays DEPTH-1, pointer wrap correct, data order preserved.
REQ-036 Reset with 3 in flight and 2 buffered -> after release resp_valid stays 0 for 2*LATENCY cycles, inflight=0, busy=0.
